// File: rtl/stream_demux_1_4.sv
// 1:4 valid/ready stream demultiplexer with a one-entry registered buffer per output channel.
// Optional per-channel delivery counters on out_cnt when DEMUX_CNT_EN is defined.
module stream_demux_1_4 #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [1:0]           in_sel,
    output logic [3:0]           out_valid,
    input  logic [3:0]           out_ready,
    output logic [4*WIDTH-1:0]   out_data
`ifdef DEMUX_CNT_EN
    ,
    output logic [4*CNT_W-1:0]   out_cnt
`endif
);

    localparam int unsigned NCH = 4;

    logic       accept;
    logic [3:0] acc_ch;
    logic [3:0] drain_ch;

    // Ready looks only at the selected channel, so a stalled channel blocks only its own traffic.
    always_comb begin
        in_ready = ~out_valid[in_sel] | out_ready[in_sel];
        accept   = in_valid & in_ready;
        acc_ch   = '0;
        drain_ch = out_valid & out_ready;
        for (int k = 0; k < NCH; k++) begin
            acc_ch[k] = accept & (in_sel == 2'(k));
        end
    end

    // An accept in the same cycle as a drain overwrites the buffer and keeps it full: no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= '0;
            out_data  <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (acc_ch[k]) begin
                    out_valid[k]                <= 1'b1;
                    out_data[k*WIDTH +: WIDTH]  <= in_data;
                end else if (drain_ch[k]) begin
                    out_valid[k]                <= 1'b0;
                end
            end
        end
    end

`ifdef DEMUX_CNT_EN
    // Per-channel output handshake counters, wrapping at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_cnt <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (drain_ch[k]) begin
                    out_cnt[k*CNT_W +: CNT_W] <= out_cnt[k*CNT_W +: CNT_W] + CNT_W'(1);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_stream_demux_1_4.sv
// Directed self-checking bench for stream_demux_1_4: routing, backpressure, throughput, reset, idle,
// and (with DEMUX_CNT_EN) counter wrap.
module tb_stream_demux_1_4;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned CNT_W = 8;

    logic                 clk;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic [1:0]           in_sel;
    logic [3:0]           out_valid;
    logic [3:0]           out_ready;
    logic [4*WIDTH-1:0]   out_data;
`ifdef DEMUX_CNT_EN
    logic [4*CNT_W-1:0]   out_cnt;
`endif

    int checks = 0;
    int errors = 0;

    stream_demux_1_4 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef DEMUX_CNT_EN
        ,
        .out_cnt   (out_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [WIDTH-1:0] d);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sel    = 2'd0;
        in_data   = '0;
        out_ready = 4'b0000;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_valid", 32'(out_valid), 32'h0);
        chk("reset_data", 32'(out_data), 32'h0);

        // Routing: a,b,c,d to channels 0..3, consumers always ready
        out_ready = 4'b1111;
        drive(1'b1, 2'd0, 4'hA);
        chk("route_rdy0", 32'(in_ready), 32'h1);
        tick();
        chk("route_v0", 32'(out_valid), 32'h1);
        chk("route_d0", 32'(out_data[3:0]), 32'hA);
        drive(1'b1, 2'd1, 4'hB);
        tick();
        chk("route_v1", 32'(out_valid), 32'h2);
        chk("route_d1", 32'(out_data[7:4]), 32'hB);
        drive(1'b1, 2'd2, 4'hC);
        tick();
        chk("route_v2", 32'(out_valid), 32'h4);
        chk("route_d2", 32'(out_data[11:8]), 32'hC);
        drive(1'b1, 2'd3, 4'hD);
        tick();
        chk("route_v3", 32'(out_valid), 32'h8);
        chk("route_d3", 32'(out_data[15:12]), 32'hD);
        drive(1'b0, 2'd0, 4'h0);
        tick();
        chk("route_empty", 32'(out_valid), 32'h0);
        chk("route_hold", 32'(out_data), 32'hDCBA);

        // Backpressure on channel 2
        out_ready = 4'b1011;
        drive(1'b1, 2'd2, 4'h5);
        chk("bp_rdy5", 32'(in_ready), 32'h1);
        tick();
        chk("bp_v5", 32'(out_valid), 32'h4);
        chk("bp_d5", 32'(out_data[11:8]), 32'h5);
        drive(1'b1, 2'd1, 4'h7);
        chk("bp_rdy7", 32'(in_ready), 32'h1);
        tick();
        chk("bp_v7", 32'(out_valid), 32'h6);
        chk("bp_d7", 32'(out_data[7:4]), 32'h7);
        chk("bp_d5_held", 32'(out_data[11:8]), 32'h5);
        drive(1'b1, 2'd2, 4'h6);
        chk("bp_rdy6_blk", 32'(in_ready), 32'h0);
        tick();
        chk("bp_v_blk", 32'(out_valid), 32'h4);
        chk("bp_d_blk", 32'(out_data[11:8]), 32'h5);
        chk("bp_rdy6_blk2", 32'(in_ready), 32'h0);
        tick();
        chk("bp_d_blk2", 32'(out_data[11:8]), 32'h5);
        out_ready = 4'b1111;
        #1;
        chk("bp_rdy6_open", 32'(in_ready), 32'h1);
        tick();
        chk("bp_v6", 32'(out_valid), 32'h4);
        chk("bp_d6", 32'(out_data[11:8]), 32'h6);
        drive(1'b0, 2'd0, 4'h0);
        tick();
        chk("bp_empty", 32'(out_valid), 32'h0);

        // Throughput: 16 back-to-back words to channel 3
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 2'd3, 4'(i));
            chk("tp_rdy", 32'(in_ready), 32'h1);
            tick();
            chk("tp_v", 32'(out_valid), 32'h8);
            chk("tp_d", 32'(out_data[15:12]), 32'(i));
        end
        drive(1'b0, 2'd0, 4'h0);
        tick();
        chk("tp_empty", 32'(out_valid), 32'h0);

        // Reset mid-operation with words held in ch0 and ch1
        out_ready = 4'b0000;
        drive(1'b1, 2'd0, 4'h1);
        tick();
        drive(1'b1, 2'd1, 4'h2);
        tick();
        drive(1'b0, 2'd0, 4'h0);
        chk("rm_held_v", 32'(out_valid), 32'h3);
        chk("rm_held_d", 32'(out_data[7:0]), 32'h21);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rm_v", 32'(out_valid), 32'h0);
        chk("rm_d", 32'(out_data), 32'h0);
        out_ready = 4'b1111;
        drive(1'b1, 2'd3, 4'h9);
        chk("rm_rdy", 32'(in_ready), 32'h1);
        tick();
        chk("rm_send_v", 32'(out_valid), 32'h8);
        chk("rm_send_d", 32'(out_data), 32'h9000);
        drive(1'b0, 2'd0, 4'h0);
        tick();
        chk("rm_empty", 32'(out_valid), 32'h0);

        // Idle: in_valid low with sel/data toggling
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b0;
            in_sel   = 2'($urandom_range(0, 3));
            in_data  = (i % 3 == 0) ? 'x : 4'($urandom);
            tick();
            chk("idle_v", 32'(out_valid), 32'h0);
            chk("idle_d", 32'(out_data), 32'h9000);
        end

`ifdef DEMUX_CNT_EN
        // Counter wrap: 257 handshakes on ch0 leave count 1
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("cnt_reset", out_cnt, 32'h0);
        for (int i = 0; i < 257; i++) begin
            drive(1'b1, 2'd0, 4'(i));
            tick();
        end
        drive(1'b0, 2'd0, 4'h0);
        tick();
        chk("cnt_wrap", out_cnt, 32'h00000001);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
